// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding and
// the default instruction word width.
package fetch_pkg;

  localparam int IW_DEFAULT = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_FULL = 3'd3;
  localparam logic [2:0] ST_DROP = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    FULL = ST_FULL,
    DROP = ST_DROP
  } state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one handshaked read to instruction memory
// for the current PC, holds the returned word in the IR and hands it to the
// decoder with valid/ready. A flush discards whatever is in flight or held.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int W  = 6,
  parameter int IW = IW_DEFAULT
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [W-1:0]  pc,
  input  logic          fetch_en,
  input  logic          flush,
  output logic          imem_req,
  output logic [W-1:0]  imem_addr,
  input  logic          imem_ack,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] ir,
  output logic [W-1:0]  ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic          pc_adv
);

  state_t        state;
  logic          drop_q;
  logic [W-1:0]  addr_q;
  logic [IW-1:0] ir_q;
  logic [W-1:0]  ir_pc_q;

  // Fetch sequencing: request, wait for data, hold the IR, or drain a
  // response that a flush has made stale.
  always_ff @(posedge clk) begin
    // NOTE: clr is sampled on the clock edge only; it is not in the
    // sensitivity list, so this is a synchronous reset.
    if (!clr) begin
      state   <= IDLE;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      ir_q    <= '0;
      ir_pc_q <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every branch
      // reads the pre-edge value of state/drop_q regardless of order.
      case (state)
        IDLE: begin
          if (fetch_en && !flush) begin
            addr_q <= pc;
            state  <= REQ;
          end
        end
        REQ: begin
          // The request stays up until acked; a flush only marks the
          // eventual response for discard.
          drop_q <= drop_q | flush;
          if (imem_ack) begin
            state <= (drop_q || flush) ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (!flush) begin
              ir_q    <= imem_rdata;
              ir_pc_q <= addr_q;
              state   <= FULL;
            end else begin
              state <= IDLE;
            end
          end else if (flush) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            drop_q <= 1'b0;
            state  <= IDLE;
          end
        end
        FULL: begin
          if (flush || ir_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state; pc_adv follows the consume
  // handshake combinationally, and flush overrides it.
  always_comb begin
    imem_req  = (state == REQ);
    imem_addr = addr_q;
    ir        = ir_q;
    ir_pc     = ir_pc_q;
    ir_valid  = (state == FULL);
    pc_adv    = (state == FULL) && ir_ready && !flush;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. Each fetch is described as a
// transaction (address, data, memory delays, flush cycle, consume delay);
// the expected per-cycle outputs follow from the transaction's timeline.
module tb_instr_fetch;

  logic        clk;
  logic        clr;
  logic [5:0]  pc;
  logic        fetch_en;
  logic        flush;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [5:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        pc_adv;

  int checks = 0;
  int errors = 0;

  // Expected architectural state carried between transactions
  logic [5:0]  model_addr;
  logic [31:0] model_ir;
  logic [5:0]  model_ir_pc;

  instr_fetch #(.W(6), .IW(32)) dut (
    .clk        (clk),
    .clr        (clr),
    .pc         (pc),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .pc_adv     (pc_adv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic req, input logic [5:0] addr,
                               input logic vld, input logic adv,
                               input logic [31:0] ir_e, input logic [5:0] irpc_e);
    check({tag, ".imem_req"},  {31'd0, imem_req},  {31'd0, req});
    check({tag, ".imem_addr"}, {26'd0, imem_addr}, {26'd0, addr});
    check({tag, ".ir_valid"},  {31'd0, ir_valid},  {31'd0, vld});
    check({tag, ".pc_adv"},    {31'd0, pc_adv},    {31'd0, adv});
    check({tag, ".ir"},        ir,                 ir_e);
    check({tag, ".ir_pc"},     {26'd0, ir_pc},     {26'd0, irpc_e});
  endtask

  // One fetch starting from IDLE. Cycle 0 presents fetch_en; the request is
  // acked at cycle 1+ack_dly, data returns rv_dly cycles after the cycle
  // following the ack, and the decoder consumes rdy_dly cycles into FULL.
  // f is the cycle of the first flush pulse (0 = no flush).
  task automatic fetch_txn(input string tag, input logic [5:0] a, input logic [31:0] d,
                           input int ack_dly, input int rv_dly, input int rdy_dly,
                           input int f);
    int  ack_c    = 1 + ack_dly;
    int  rv_c     = ack_c + 1 + rv_dly;
    int  rdy_c    = rv_c + 1 + rdy_dly;
    int  ff       = (f == 0) ? (1 << 30) : f;
    bit  early    = (ff <= rv_c);
    int  end_full = (ff < rdy_c) ? ff : rdy_c;
    int  last     = early ? rv_c : end_full;
    bit  in_full;
    logic       e_req;
    logic [5:0] e_addr;
    logic       e_adv;
    for (int c = 0; c <= last; c++) begin
      in_full     = !early && (c > rv_c) && (c <= end_full);
      pc          = (c == 0) ? a : 6'($urandom);
      fetch_en    = (c == 0) ? 1'b1 : 1'($urandom_range(1));
      flush       = (c == ff) || (early && c > ff && c <= rv_c && ($urandom_range(1) == 1));
      imem_ack    = (c == ack_c);
      imem_rvalid = (c == rv_c) || (c == 0 && ($urandom_range(1) == 1));
      imem_rdata  = (c == rv_c) ? d : 32'($urandom);
      ir_ready    = in_full ? (c == rdy_c) : 1'($urandom_range(1));
      if (!early && c == rv_c + 1) begin
        model_ir    = d;
        model_ir_pc = a;
      end
      e_req  = (c >= 1) && (c <= ack_c);
      e_addr = (c == 0) ? model_addr : a;
      e_adv  = in_full && (c == rdy_c) && (rdy_c < ff);
      @(negedge clk);
      check_outputs(tag, e_req, e_addr, in_full, e_adv, model_ir, model_ir_pc);
      step();
    end
    model_addr = a;
  endtask

  initial begin
    clr         = 1'b0;
    pc          = 6'd0;
    fetch_en    = 1'b0;
    flush       = 1'b0;
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    ir_ready    = 1'b0;
    model_addr  = 6'd0;
    model_ir    = 32'd0;
    model_ir_pc = 6'd0;

    // Reset state
    step();
    step();
    @(negedge clk);
    check_outputs("reset", 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 6'd0);
    step();
    clr = 1'b1;

    // Directed cases
    fetch_txn("basic",      6'd5,  32'h8C010004, 0, 0, 0, 0);
    fetch_txn("stall",      6'd17, 32'h12345678, 3, 2, 2, 0);
    fetch_txn("flush_wait", 6'd22, 32'hDEADBEEF, 0, 2, 0, 2);
    fetch_txn("after_fl",   6'd9,  32'h0000A5A5, 0, 0, 1, 0);
    fetch_txn("flush_rdy",  6'd40, 32'hCAFEF00D, 0, 0, 0, 3);
    fetch_txn("flush_req",  6'd63, 32'h55AA55AA, 2, 0, 0, 1);
    fetch_txn("refill",     6'd0,  32'hFFFFFFFF, 1, 1, 0, 0);

    // Reset while waiting for data, then a stray response
    pc = 6'd12; fetch_en = 1'b1; flush = 1'b0; imem_ack = 1'b0;
    imem_rvalid = 1'b0; ir_ready = 1'b0;
    step();
    fetch_en = 1'b0; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; clr = 1'b0;
    step();
    clr = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0BADF00D; ir_ready = 1'b1;
    @(negedge clk);
    check_outputs("rst_wait", 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 6'd0);
    step();
    imem_rvalid = 1'b0; ir_ready = 1'b0;
    @(negedge clk);
    check_outputs("rst_stray", 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 6'd0);
    step();
    model_addr  = 6'd0;
    model_ir    = 32'd0;
    model_ir_pc = 6'd0;

    // Randomized transactions
    for (int n = 0; n < 300; n++) begin
      int ad = $urandom_range(3);
      int rd = $urandom_range(3);
      int cd = $urandom_range(3);
      int rc = 1 + ad + 1 + rd + 1 + cd;
      int fc = ($urandom_range(2) == 0) ? 0 : $urandom_range(rc + 1, 1);
      fetch_txn("rand", 6'($urandom), 32'($urandom), ad, rd, cd, fc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the multicycle MIPS datapath, directly downstream of the PC register. It takes the current PC address and issues a handshaked read to instruction memory. It captures the returned word into the instruction register (IR) and presents it to the controller/decoder with a valid/ready handshake. When the instruction is consumed, it pulses `pc_adv` so the PC advances; a taken branch uses `flush` to discard any in-flight or held instruction.

## Interface
- `W`, 6 — instruction address width; matches the PC register width.
- `IW`, 32 — instruction word width.

- `clk`  in  1  — single clock; all state changes on the rising edge.
- `clr`  in  1  — synchronous, active-low reset.
- `pc`  in  W  — current PC address from the PC register.
- `fetch_en`  in  1  — controller requests a fetch (level-sensitive).
- `flush`  in  1  — discard the in-flight or held instruction (branch taken).
- `imem_req`  out  1  — read request to instruction memory.
- `imem_addr`  out  W  — read address; stable while `imem_req` is high.
- `imem_ack`  in  1  — memory accepted the request.
- `imem_rvalid`  in  1  — read data valid; earliest one cycle after `imem_ack`.
- `imem_rdata`  in  IW  — read data.
- `ir`  out  IW  — instruction register contents.
- `ir_pc`  out  W  — address the word in `ir` was fetched from.
- `ir_valid`  out  1  — `ir` holds an unconsumed instruction.
- `ir_ready`  in  1  — decoder consumes `ir` this cycle.
- `pc_adv`  out  1  — one-cycle PC-advance enable.

## Operation
- FSM states: IDLE, REQ, WAIT, FULL, DROP. Register `drop_q` tracks a flush seen while in REQ.
- **IDLE**
  - `fetch_en & !flush` → REQ; `addr_q <= pc`.
  - Otherwise stay in IDLE.
  - `imem_rvalid` is ignored.
- **REQ**
  - `imem_req = 1`; `imem_addr = addr_q`.
  - The request is never retracted before `imem_ack`.
  - `flush` sets `drop_q`.
  - On `imem_ack`: → DROP if `drop_q | flush`, else → WAIT.
- **WAIT**
  - On `imem_rvalid & !flush`: `ir <= imem_rdata`, `ir_pc <= addr_q`, → FULL.
  - On `flush` without `imem_rvalid`: → DROP.
  - On `flush & imem_rvalid` together: data discarded, → IDLE.
- **DROP**
  - Wait for `imem_rvalid`, discard the data, clear `drop_q`, → IDLE.
  - `flush` in DROP has no further effect.
- **FULL**
  - `ir_valid = 1`.
  - `ir_ready & !flush`: `pc_adv = 1` this cycle, → IDLE.
  - `flush` (with or without `ir_ready`): → IDLE, `pc_adv = 0`; flush wins.
  - `ir` and `ir_pc` keep their value after leaving FULL. Only `ir_valid` qualifies them.
- **Output derivation**
  - `imem_req = (state == REQ)`.
  - `ir_valid = (state == FULL)`.
  - `pc_adv = (state == FULL) & ir_ready & !flush`, combinational.
  - All other outputs are registered.
- **Width rules**
  - No arithmetic; `addr_q` is captured verbatim.
  - Address wrap is owned by the PC register.

## Timing
- **Reset values** (`clr == 0` at an edge):
  - state = IDLE, `drop_q = 0`.
  - `imem_req = 0`, `imem_addr = 0`.
  - `ir = 0`, `ir_pc = 0`, `ir_valid = 0`, `pc_adv = 0`.
- Reset in any state, including WAIT or DROP, returns to IDLE. A late `imem_rvalid` after reset is ignored.
- **Best-case latency**, counted from `fetch_en` sampled in IDLE at cycle 0:
  - cycle 1: `imem_req` high; `imem_ack` arrives in the same cycle.
  - cycle 2: `imem_rvalid` high.
  - cycle 3: `ir_valid` high.
- Memory stalls (late `imem_ack` or late `imem_rvalid`) extend REQ or WAIT cycle for cycle.
- `pc_adv` at cycle N means the PC updates at the edge ending cycle N. IDLE samples the new `pc` in cycle N+1.
- At most one outstanding memory request at any time.

## Structure
- Shared package `fetch_pkg`:
  - state encoding localparams (IDLE=0, REQ=1, WAIT=2, FULL=3, DROP=4; 3 bits);
  - default `IW`.
- Single module; no sub-module. The IR/`ir_pc` holding register is inline.

## Test plan
- **Basic fetch.** `pc=5`, `fetch_en` held, memory acks at once, `rvalid` one cycle later with `0x8C010004` → `imem_addr=5` in cycle 1, `ir=0x8C010004`, `ir_pc=5`, `ir_valid=1` at cycle 3. `ir_ready` in cycle 3 → `pc_adv` high for exactly that cycle.
- **Memory stall.** `imem_ack` delayed 3 cycles, then `rvalid` delayed 2 more → `imem_req` and `imem_addr` stay stable for 4 cycles; `ir_valid` rises the cycle after `rvalid`; no `pc_adv` until `ir_ready`.
- **Flush in WAIT.** `flush` one cycle after ack; `rvalid` with `0xDEADBEEF` 2 cycles later → FSM passes through DROP; `ir` unchanged, `ir_valid` stays 0, no `pc_adv`. A new `fetch_en` with `pc=9` then fetches address 9.
- **Flush and ready together in FULL.** `ir_valid=1`, `flush=1` and `ir_ready=1` → `pc_adv=0`, `ir_valid=0` next cycle.
- **Flush in REQ before ack.** `flush` while `imem_req` is high, ack 2 cycles later → `imem_req` is not dropped early, the response is discarded, and the FSM returns to IDLE.
- **Reset mid-WAIT.** `clr=0` for 1 cycle, then a stray `rvalid` → all outputs at reset values; the stray `rvalid` is ignored and `ir_valid` stays 0.
